// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
// Tear-free updates: loads wait in a shadow register until the frame boundary.
module seg7_scan_ctrl #(
  parameter int CLK_DIV = 1000,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  dig
);

  typedef enum logic {ST_GAP, ST_SHOW} state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CNT_GAP  = 16'(GAP_CYC);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  state_t      state_q, state_d;
  logic        wrap, frame_end;

  logic [15:0] disp_data_q, sh_data_q;
  logic [3:0]  disp_dp_q, sh_dp_q;
  logic        disp_blz_q, sh_blz_q;
  logic        pending_q;

  logic [3:0]  nib;
  logic [3:0]  supp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  assign ready = ~pending_q;

  // State is registered from the next counter value so it tracks cnt_q exactly.
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    frame_end = wrap && (idx_q == 2'd3);
    cnt_d     = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;
    state_d   = (cnt_d < CNT_GAP) ? ST_GAP : ST_SHOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= ST_GAP;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_blz_q  <= 1'b0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blz_q    <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      // Transfer and accept are exclusive: accept needs pending=0, transfer pending=1.
      if (frame_end && pending_q) begin
        disp_data_q <= sh_data_q;
        disp_dp_q   <= sh_dp_q;
        disp_blz_q  <= sh_blz_q;
        pending_q   <= 1'b0;
      end
      if (load && !pending_q) begin
        sh_data_q <= data;
        sh_dp_q   <= dp_in;
        sh_blz_q  <= blank_lz;
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nib     = disp_data_q[{idx_q, 2'b00} +: 4];
    supp[3] = disp_blz_q && (disp_data_q[15:12] == 4'h0);
    supp[2] = supp[3] && (disp_data_q[11:8] == 4'h0);
    supp[1] = supp[2] && (disp_data_q[7:4] == 4'h0);
    supp[0] = 1'b0;
    dig = 4'b0000;
    seg = 7'h00;
    dp  = 1'b0;
    if (state_q == ST_SHOW && !supp[idx_q]) begin
      dig = 4'b0001 << idx_q;
      seg = hex_to_seg(nib);
      dp  = disp_dp_q[idx_q];
    end
  end

endmodule
